// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the decode/ALU-issue stage:
//   - ALU_FUN_W      : width of the one-hot ALU control vector
//   - alu_bit_e      : bit index of each ALU function inside that vector
//   - OPC_*          : RV32I major opcodes recognised by the decoder
//   - op1_sel_e /
//     op2_sel_e      : operand source selects produced by the decoder
//   - alu_onehot()   : turns a bit index into the one-hot control vector
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_FUN_W = 11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_PASS = 4'd10
    } alu_bit_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        OP1_RS1 = 2'd0,
        OP1_PC  = 2'd1,
        OP1_IMM = 2'd2
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_ZERO = 2'd2
    } op2_sel_e;

    function automatic logic [ALU_FUN_W-1:0] alu_onehot(input alu_bit_e b);
        return {{(ALU_FUN_W-1){1'b0}}, 1'b1} << b;
    endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// -----------------------------------------------------------------------------
// alu_fun_decode
// Purely combinational RV32I decoder for the ALU issue stage.
// Ports:
//   instr_i    [31:0]          instruction word
//   alu_fun_o  [ALU_FUN_W-1:0] one-hot ALU control (all-zero for non-ALU ops)
//   op1_sel_o                  operand-1 source (rs1 / pc / immediate)
//   op2_sel_o                  operand-2 source (rs2 / immediate / zero)
//   imm_o      [XLEN-1:0]      immediate for the instruction's format
//   rd_we_o                    destination write enable (0 when rd = x0)
//   illegal_o                  unrecognised major opcode
// -----------------------------------------------------------------------------
module alu_fun_decode
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ALU_FUN_W = alu_pkg::ALU_FUN_W
) (
    input  logic [31:0]          instr_i,
    output logic [ALU_FUN_W-1:0] alu_fun_o,
    output op1_sel_e             op1_sel_o,
    output op2_sel_e             op2_sel_o,
    output logic [XLEN-1:0]      imm_o,
    output logic                 rd_we_o,
    output logic                 illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    alu_bit_e        f3_fun;
    alu_bit_e        fun_sel;
    logic            fun_en;
    logic            we;

    assign opcode    = instr_i[6:0];
    assign rd        = instr_i[11:7];
    assign funct3    = instr_i[14:12];
    assign funct7_b5 = instr_i[30];

    // Size casts of signed values sign-extend to XLEN.
    assign imm_i = XLEN'($signed(instr_i[31:20]));
    assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_u = XLEN'($signed({instr_i[31:12], 12'h000}));

    // Base function shared by OP and OP-IMM before the funct7[5] alternates.
    always_comb begin
        f3_fun = ALU_ADD;
        case (funct3)
            3'b000:  f3_fun = ALU_ADD;
            3'b001:  f3_fun = ALU_SLL;
            3'b010:  f3_fun = ALU_SLT;
            3'b011:  f3_fun = ALU_SLTU;
            3'b100:  f3_fun = ALU_XOR;
            3'b101:  f3_fun = ALU_SRL;
            3'b110:  f3_fun = ALU_OR;
            default: f3_fun = ALU_AND;
        endcase
    end

    always_comb begin
        fun_en    = 1'b0;
        fun_sel   = ALU_ADD;
        op1_sel_o = OP1_RS1;
        op2_sel_o = OP2_RS2;
        imm_o     = imm_i;
        we        = 1'b0;
        illegal_o = 1'b0;
        case (opcode)
            OPC_OP: begin
                fun_en  = 1'b1;
                we      = 1'b1;
                fun_sel = f3_fun;
                if (funct7_b5 && funct3 == 3'b000) fun_sel = ALU_SUB;
                if (funct7_b5 && funct3 == 3'b101) fun_sel = ALU_SRA;
            end
            OPC_OP_IMM: begin
                // I-imm[4:0] is the shift amount, so op2[4:0]=shamt for shifts.
                fun_en    = 1'b1;
                we        = 1'b1;
                op2_sel_o = OP2_IMM;
                fun_sel   = f3_fun;
                if (funct7_b5 && funct3 == 3'b101) fun_sel = ALU_SRA;
            end
            OPC_LUI: begin
                fun_en    = 1'b1;
                we        = 1'b1;
                fun_sel   = ALU_PASS;
                op1_sel_o = OP1_IMM;
                op2_sel_o = OP2_ZERO;
                imm_o     = imm_u;
            end
            OPC_AUIPC: begin
                fun_en    = 1'b1;
                we        = 1'b1;
                op1_sel_o = OP1_PC;
                op2_sel_o = OP2_IMM;
                imm_o     = imm_u;
            end
            OPC_LOAD: begin
                fun_en    = 1'b1;
                we        = 1'b1;
                op2_sel_o = OP2_IMM;
            end
            OPC_STORE: begin
                fun_en    = 1'b1;
                op2_sel_o = OP2_IMM;
                imm_o     = imm_s;
            end
            OPC_JAL, OPC_JALR: begin
                we = 1'b1;
            end
            OPC_BRANCH, OPC_FENCE, OPC_SYSTEM: begin
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    assign alu_fun_o = fun_en ? ALU_FUN_W'(alu_onehot(fun_sel)) : '0;
    assign rd_we_o   = we & (rd != 5'd0);

endmodule

// File: rtl/decode_alu_stage.sv
// -----------------------------------------------------------------------------
// decode_alu_stage
// Single-entry decode / ALU-issue pipeline register with valid/ready handshake.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   valid_i / ready_o           upstream handshake (ready_o = ready_i | ~valid_o)
//   instr_i, pc_i               instruction word and its PC
//   rs1_data_i, rs2_data_i      forwarded register-file read data
//   flush_i                     kills both the held and the incoming instruction
//   valid_o / ready_i           downstream (execute) handshake
//   op1_o, op2_o                registered ALU operands
//   alu_fun_o                   registered one-hot ALU control
//   rd_o, rd_we_o, pc_o         registered destination, write enable, PC
//   illegal_o                   registered illegal-opcode flag
// -----------------------------------------------------------------------------
module decode_alu_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ALU_FUN_W = alu_pkg::ALU_FUN_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instr_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      op1_o,
    output logic [XLEN-1:0]      op2_o,
    output logic [ALU_FUN_W-1:0] alu_fun_o,
    output logic [4:0]           rd_o,
    output logic                 rd_we_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 illegal_o
);

    logic [ALU_FUN_W-1:0] dec_fun;
    op1_sel_e             dec_op1_sel;
    op2_sel_e             dec_op2_sel;
    logic [XLEN-1:0]      dec_imm;
    logic                 dec_we;
    logic                 dec_ill;
    logic [XLEN-1:0]      op1_d;
    logic [XLEN-1:0]      op2_d;
    logic                 load;
    logic                 drain;

    alu_fun_decode #(
        .XLEN      (XLEN),
        .ALU_FUN_W (ALU_FUN_W)
    ) u_alu_fun_decode (
        .instr_i   (instr_i),
        .alu_fun_o (dec_fun),
        .op1_sel_o (dec_op1_sel),
        .op2_sel_o (dec_op2_sel),
        .imm_o     (dec_imm),
        .rd_we_o   (dec_we),
        .illegal_o (dec_ill)
    );

    always_comb begin
        op1_d = rs1_data_i;
        case (dec_op1_sel)
            OP1_PC:  op1_d = pc_i;
            OP1_IMM: op1_d = dec_imm;
            default: op1_d = rs1_data_i;
        endcase
    end

    always_comb begin
        op2_d = rs2_data_i;
        case (dec_op2_sel)
            OP2_IMM:  op2_d = dec_imm;
            OP2_ZERO: op2_d = '0;
            default:  op2_d = rs2_data_i;
        endcase
    end

    // Depends only on downstream state, never on valid_i.
    assign ready_o = ready_i | ~valid_o;
    assign load    = valid_i & ready_o & ~flush_i;
    assign drain   = valid_o & ready_i;

    // Control fields: cleared whenever the stage is empty so alu_fun_o is
    // all-zero while valid_o=0. Flush outranks load and drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            alu_fun_o <= '0;
            rd_we_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            alu_fun_o <= '0;
            rd_we_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (load) begin
            valid_o   <= 1'b1;
            alu_fun_o <= dec_fun;
            rd_we_o   <= dec_we;
            illegal_o <= dec_ill;
        end else if (drain) begin
            valid_o   <= 1'b0;
            alu_fun_o <= '0;
            rd_we_o   <= 1'b0;
            illegal_o <= 1'b0;
        end
    end

    // Payload fields only move on a load; otherwise they hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op1_o <= '0;
            op2_o <= '0;
            pc_o  <= '0;
            rd_o  <= '0;
        end else if (load) begin
            op1_o <= op1_d;
            op2_o <= op2_d;
            pc_o  <= pc_i;
            rd_o  <= instr_i[11:7];
        end
    end

endmodule

// File: tb/tb_decode_alu_stage.sv
module tb_decode_alu_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [10:0] alu_fun_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic [31:0] pc_o;
    logic        illegal_o;

    decode_alu_stage #(.XLEN(32), .ALU_FUN_W(11)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .op1_o(op1_o), .op2_o(op2_o), .alu_fun_o(alu_fun_o), .rd_o(rd_o),
        .rd_we_o(rd_we_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic [10:0] fun;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } pay_t;

    int   checks = 0;
    int   failures = 0;
    int   xfer_dut = 0;
    int   xfer_ref = 0;
    logic m_valid = 1'b0;
    pay_t m = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    // Reference: expected stage payload straight from the RV32I field rules.
    // For OP/OP-IMM the ALU bit index equals funct3, with SUB=8 and SRA=9.
    function automatic pay_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        pay_t        r;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] u_imm;
        int          idx;
        f3    = ins[14:12];
        alt   = ins[30];
        i_imm = {{20{ins[31]}}, ins[31:20]};
        s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        u_imm = {ins[31:12], 12'h000};
        r     = '0;
        r.op1 = a;
        r.op2 = b;
        r.pc  = pc;
        r.rd  = ins[11:7];
        idx   = -1;
        case (ins[6:0])
            7'h33: begin
                idx = int'(f3);
                if (alt && f3 == 3'd0) idx = 8;
                if (alt && f3 == 3'd5) idx = 9;
                r.we = 1'b1;
            end
            7'h13: begin
                r.op2 = i_imm;
                idx = int'(f3);
                if (alt && f3 == 3'd5) idx = 9;
                r.we = 1'b1;
            end
            7'h37: begin r.op1 = u_imm; r.op2 = 32'd0; idx = 10; r.we = 1'b1; end
            7'h17: begin r.op1 = pc; r.op2 = u_imm; idx = 0; r.we = 1'b1; end
            7'h03: begin r.op2 = i_imm; idx = 0; r.we = 1'b1; end
            7'h23: begin r.op2 = s_imm; idx = 0; end
            7'h63, 7'h0F, 7'h73: begin end
            7'h6F, 7'h67: r.we = 1'b1;
            default: r.ill = 1'b1;
        endcase
        r.fun = (idx < 0) ? 11'd0 : (11'd1 << idx);
        if (r.rd == 5'd0) r.we = 1'b0;
        return r;
    endfunction

    task automatic check_outputs();
        chk("valid_o", valid_o, m_valid);
        chk("alu_fun_o", alu_fun_o, m.fun);
        chk("rd_we_o", rd_we_o, m.we);
        chk("illegal_o", illegal_o, m.ill);
        chk("onehot0", $onehot0(alu_fun_o), 1'b1);
        if (m_valid) begin
            chk("rd_o", rd_o, m.rd);
            chk("pc_o", pc_o, m.pc);
            if (!m.ill) begin
                chk("op1_o", op1_o, m.op1);
                chk("op2_o", op2_o, m.op2);
            end
        end
    endtask

    // One clock: inputs are already driven; update model, clock, compare.
    task automatic cycle();
        pay_t d;
        logic exp_ready;
        #1;
        exp_ready = ready_i | ~m_valid;
        chk("ready_o", ready_o, exp_ready);
        if (valid_o && ready_i) xfer_dut++;
        if (m_valid && ready_i) xfer_ref++;
        d = ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i);
        if (flush_i) begin
            m_valid = 1'b0; m.fun = '0; m.we = 1'b0; m.ill = 1'b0;
        end else if (valid_i && (ready_i || !m_valid)) begin
            m_valid = 1'b1; m = d;
        end else if (m_valid && ready_i) begin
            m_valid = 1'b0; m.fun = '0; m.we = 1'b0; m.ill = 1'b0;
        end
        @(posedge clk_i);
        #1;
        check_outputs();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk("rst valid_o", valid_o, 1'b0);
        chk("rst alu_fun_o", alu_fun_o, 11'd0);
        chk("rst rd_we_o", rd_we_o, 1'b0);
        chk("rst illegal_o", illegal_o, 1'b0);
        chk("rst op1_o", op1_o, 32'd0);
        chk("rst op2_o", op2_o, 32'd0);
        chk("rst pc_o", pc_o, 32'd0);
        chk("rst rd_o", rd_o, 5'd0);
        m_valid = 1'b0;
        m = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        ready_i = 1'b0;
        #1;
        chk("post-reset ready_o", ready_o, 1'b1);
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();

        // ADD x3,x1,x2
        valid_i = 1'b1; ready_i = 1'b1; rs1_data_i = 32'd5; rs2_data_i = 32'd7; pc_i = 32'h100;
        instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
        cycle();
        chk("add op1", op1_o, 32'd5);
        chk("add op2", op2_o, 32'd7);
        chk("add fun", alu_fun_o, 11'h001);
        chk("add rd", rd_o, 5'd3);
        chk("add we", rd_we_o, 1'b1);

        // SRAI x4,x1,3 then SUB x5,x1,x2 back to back
        instr_i = enc_i(12'h403, 5'd1, 3'd5, 5'd4, 7'h13);
        cycle();
        chk("srai fun", alu_fun_o, 11'h200);
        chk("srai shamt", op2_o[4:0], 5'd3);
        instr_i = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33);
        cycle();
        chk("sub fun", alu_fun_o, 11'h100);
        chk("sub op2", op2_o[4:0], 5'd7);
        valid_i = 1'b0;
        cycle();

        // LUI x6,0xABCDE held for 3 stalled cycles
        valid_i = 1'b1; ready_i = 1'b0;
        instr_i = {20'hABCDE, 5'd6, 7'h37};
        cycle();
        instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd7, 7'h33);
        for (int i = 0; i < 3; i++) begin
            chk("lui stall ready_o", ready_o, 1'b0);
            cycle();
            chk("lui op1", op1_o, 32'hABCDE000);
            chk("lui fun", alu_fun_o, 11'h400);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        cycle();

        // Flush while stalled with a valid incoming instruction
        valid_i = 1'b1; ready_i = 1'b0;
        instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33);
        cycle();
        flush_i = 1'b1;
        cycle();
        chk("flush valid", valid_o, 1'b0);
        chk("flush fun", alu_fun_o, 11'd0);
        chk("flush we", rd_we_o, 1'b0);
        flush_i = 1'b0; ready_i = 1'b1;

        // Illegal opcode, then ADDI x0,x0,1
        instr_i = 32'h0000_0FFF;
        cycle();
        chk("illegal flag", illegal_o, 1'b1);
        chk("illegal fun", alu_fun_o, 11'd0);
        chk("illegal we", rd_we_o, 1'b0);
        instr_i = enc_i(12'h001, 5'd0, 3'd0, 5'd0, 7'h13);
        cycle();
        chk("addi x0 we", rd_we_o, 1'b0);
        chk("addi x0 fun", alu_fun_o, 11'h001);

        // Reset while stalled discards the held instruction
        ready_i = 1'b0;
        instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9, 7'h33);
        cycle();
        cycle();
        do_reset();
        valid_i = 1'b0;
        cycle();

        // Randomized stream with a reset pulse in the middle
        for (int n = 0; n < 1500; n++) begin
            logic [6:0] opcs[15];
            opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F,
                     7'h67, 7'h0F, 7'h73, 7'h7F, 7'h00, 7'h0B, 7'h2B};
            if (n == 700) do_reset();
            valid_i    = ($urandom_range(0, 3) != 0);
            ready_i    = ($urandom_range(0, 2) != 0);
            flush_i    = ($urandom_range(0, 15) == 0);
            instr_i    = $urandom;
            instr_i[6:0] = opcs[$urandom_range(0, 14)];
            pc_i       = $urandom;
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            cycle();
        end
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        cycle();
        chk("transfer count", xfer_dut, xfer_ref);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_alu_stage.md
DECODE_ALU_STAGE -- requirements
Module: decode_alu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ALU_FUN_W, default 11, one-hot ALU control width.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_i  input  1  upstream instruction valid.
REQ-006 SHALL have port ready_o  output  1  stage can accept this cycle.
REQ-007 SHALL have port instr_i  input  32  RV32I instruction word.
REQ-008 SHALL have port pc_i  input  XLEN  instruction PC.
REQ-009 SHALL have port rs1_data_i / rs2_data_i  input  XLEN each  register-file read data, already forwarded.
REQ-010 SHALL have port flush_i  input  1  kill held and incoming instruction.
REQ-011 SHALL have port valid_o  output  1  execute-stage payload valid.
REQ-012 SHALL have port ready_i  input  1  execute stage accepts.
REQ-013 SHALL have ports op1_o, op2_o  output  XLEN  registered ALU operands.
REQ-014 SHALL have port alu_fun_o  output  ALU_FUN_W  registered one-hot ALU control.
REQ-015 SHALL have ports rd_o (5), rd_we_o (1), pc_o (XLEN), illegal_o (1)  outputs  registered destination, write enable, PC, illegal-opcode flag.

Function
REQ-016 alu_fun bit map SHALL be: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA, 10 PASS-op1.
REQ-017 alu_fun_o SHALL be $onehot or all-zero at every cycle; all-zero whenever valid_o=0.
REQ-018 OP (0110011): op1=rs1, op2=rs2; funct3 decodes to bits 0..7 and 9 as mapped; funct7[5]=1 with funct3 000 selects SUB, with 101 selects SRA.
REQ-019 OP-IMM (0010011): op1=rs1, op2=sign-extended I-imm; funct3 000 always ADD; 101 with funct7[5]=1 selects SRA, else SRL; op2[4:0]=shamt.
REQ-020 LUI: op1={imm[31:12],12'b0}, op2=0, PASS; AUIPC: op1=pc_i, op2=U-imm, ADD.
REQ-021 LOAD: op1=rs1, op2=I-imm, ADD, rd_we=1; STORE: op1=rs1, op2=S-imm, ADD, rd_we=0.
REQ-022 Branch, JAL, JALR, FENCE, SYSTEM: alu_fun=0, op1/op2=rs1/rs2, rd_we=1 only for JAL/JALR.
REQ-023 Any other opcode: alu_fun=0, rd_we=0, illegal_o=1; illegal_o=0 otherwise.
REQ-024 rd_we SHALL be forced 0 when rd=x0.
REQ-025 ready_o SHALL equal ready_i | ~valid_o (combinational, no path from valid_i).
REQ-026 Load: when valid_i & ready_o & ~flush_i, all outputs update next edge and valid_o=1; latency exactly one cycle.
REQ-027 Drain: when valid_o & ready_i and no load, valid_o SHALL clear next edge and alu_fun_o, rd_we_o, illegal_o SHALL clear.
REQ-028 Stall: when valid_o & ~ready_i, every output SHALL hold bit-stable.
REQ-029 Simultaneous drain and load SHALL pass the new instruction with no bubble.
REQ-030 flush_i SHALL take priority over load/hold/drain: next edge valid_o=0, alu_fun_o=0, rd_we_o=0, illegal_o=0; op1/op2/pc/rd don't-care.

Reset
REQ-031 On rst_ni=0, immediately: valid_o=0, alu_fun_o=0, rd_we_o=0, illegal_o=0, op1_o=op2_o=pc_o=0, rd_o=0.
REQ-032 Reset mid-stall SHALL discard the held instruction; first post-reset cycle ready_o=1.

Structure
REQ-033 alu_pkg SHALL hold ALU_FUN_W, the bit-index enum of REQ-016, and RV32I opcode localparams.
REQ-034 Combinational decode SHALL live in sub-module alu_fun_decode (instr -> alu_fun, op selects, imm, rd_we, illegal); decode_alu_stage holds the register and handshake.

Verification
REQ-035 ADD x3,x1,x2 (rs1=5, rs2=7), ready_i=1 -> next cycle valid_o=1, op1=5, op2=7, alu_fun_o=11'h001, rd_o=3, rd_we_o=1.
REQ-036 SRAI x4,x1,3 then SUB x5,x1,x2 back-to-back -> alu_fun_o 11'h200 then 11'h100, op2[4:0]=3 then rs2.
REQ-037 LUI x6,0xABCDE with ready_i=0 for 3 cycles -> op1_o=32'hABCDE000, alu_fun_o=11'h400 held stable, ready_o=0, accepted on release.
REQ-038 flush_i with valid_i=1 while stalled -> next cycle valid_o=0, alu_fun_o=0, rd_we_o=0.
REQ-039 Opcode 7'b1111111 -> illegal_o=1, alu_fun_o=0, rd_we_o=0; ADDI x0,x0,1 -> rd_we_o=0.
REQ-040 Random stream with random ready_i/flush_i and mid-run rst_ni pulse -> $onehot0(alu_fun_o) every cycle, no instruction lost or duplicated vs. reference model.
